mem_arbiter: RTL

Two-requester arbiter that shares one single-port, synchronous-read word memory between the instruction-fetch port and the data load/store port of the MIPS core. It sits between the processor and a unified memory, and is needed wherever fetch and data access must contend for one array, such as a multicycle or pipelined core with a single memory. It grants at most one access per cycle and returns read data one cycle after grant. It routes the returned data to the requester that issued the read.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/mem_arbiter_arb2_pick.sv | 42 ++++
 rtl/mem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
// Used by mem_arbiter and arb2_pick.
package mips_mem_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned AW_DEF = 6;

    // Owner encoding for the round-robin pointer: the last contested winner.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_arbiter_arb2_pick.sv
// Two-way fetch/data picker producing a one-hot grant.
// With MEM_ARB_RR_EN defined, a last-winner pointer alternates contested grants.
module arb2_pick
    import mips_mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic i_req_f,
    input  logic i_req_d,
    output logic o_gnt_f,
    output logic o_gnt_d
);

`ifdef MEM_ARB_RR_EN
    logic r_last;
    logic w_contest;

    assign w_contest = i_req_f & i_req_d;

    // Reset to "fetch won last" so data takes the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= OWN_I;
        end else if (w_contest) begin
            r_last <= o_gnt_d ? OWN_D : OWN_I;
        end
    end

    always_comb begin
        o_gnt_d = i_req_d & (~i_req_f | (r_last == OWN_I));
        o_gnt_f = i_req_f & ~o_gnt_d;
    end
`else
    always_comb begin
        o_gnt_d = i_req_d;
        o_gnt_f = i_req_f & ~i_req_d;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read word memory between fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    resp_state_t r_state;
    resp_state_t w_next;
    logic        w_req_f;
    logic        w_req_d;
    logic        w_gnt_f;
    logic        w_gnt_d;
    logic        w_unused;

    // Masking requests during reset blocks grants and keeps the pointer still.
    assign w_req_f = i_req & ~reset;
    assign w_req_d = d_req & ~reset;

    assign w_unused = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    arb2_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk     (clk),
        .reset   (reset),
`endif
        .i_req_f (w_req_f),
        .i_req_d (w_req_d),
        .o_gnt_f (w_gnt_f),
        .o_gnt_d (w_gnt_d)
    );

    assign i_ready = w_gnt_f;
    assign d_ready = w_gnt_d;

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        w_next  = IDLE;
        if (w_gnt_d) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[AW+1:2];
            m_wdata = d_wdata;
            w_next  = d_we ? IDLE : RESP_D;
        end else if (w_gnt_f) begin
            m_en    = 1'b1;
            m_addr  = i_addr[AW+1:2];
            w_next  = RESP_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A pending response is dropped as soon as reset is seen.
    assign i_rvalid = (r_state == RESP_I) & ~reset;
    assign d_rvalid = (r_state == RESP_D) & ~reset;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
